datamem: RTL and testbench
==========================

DATAMEM -- requirements
Module: datamem

Interface
REQ-001 Parameter WORD_SIZE, 32, address and word width in bits.
REQ-002 Parameter BLOCK_BYTES, 128, bytes per block; block offset is address bits [6:0].
REQ-003 Parameter BLOCK_SIZE, BLOCK_BYTES*8 (1024), block width in bits.
REQ-004 Parameter MEM_BLOCKS, 64, number of stored blocks (power of two); capacity MEM_BLOCKS*BLOCK_BYTES bytes.
REQ-005 Port clk  input  1  clock; all state changes on rising edge except reset.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port in  input  WORD_SIZE  byte address; block number = in[31:7], bits [6:0] ignored.
REQ-008 Port readable  input  1  read request, sampled on rising clk.
REQ-009 Port writable  input  1  write request, sampled on rising clk.
REQ-010 Port write  input  BLOCK_SIZE  block write data.
REQ-011 Port out1  output  BLOCK_SIZE  registered block at the addressed block.
REQ-012 Port out2  output  BLOCK_SIZE  registered block at the next sequential block (addressed block + 1).
REQ-013 Port flush  input  1  halt indication from cache after final write-backs.

Function
REQ-014 Storage SHALL be MEM_BLOCKS entries of BLOCK_SIZE bits, indexed by idx = in[31:7] mod MEM_BLOCKS (upper bits wrap silently).
REQ-015 Byte order SHALL be big-endian within a block: byte offset 0 occupies bits [BLOCK_SIZE-1 -: 8], offset k occupies bits [BLOCK_SIZE-1-8k -: 8].
REQ-016 Read: on rising clk with readable=1, out1 SHALL load mem[idx] and out2 SHALL load mem[(idx+1) mod MEM_BLOCKS]; latency exactly 1 cycle.
REQ-017 With readable=0, out1/out2 SHALL hold their last values.
REQ-018 Write: on rising clk with writable=1 and not halted, mem[idx] SHALL be replaced by the full write block (whole-block write, no byte enables).
REQ-019 Simultaneous readable=1 and writable=1 to the same idx: out1 SHALL return the pre-write contents; write takes effect for subsequent reads.
REQ-020 Simultaneous read/write where write idx equals read idx+1: out2 SHALL return pre-write contents.
REQ-021 Last block (idx = MEM_BLOCKS-1): out2 SHALL wrap to block 0.
REQ-022 No handshake; the requester SHALL hold in/write stable during the sampling edge; one request of each kind per cycle.
REQ-023 Halted state: rising clk with flush=1 SHALL set an internal halted flag; once halted, writes SHALL be ignored, reads SHALL still be serviced.
REQ-024 flush=1 and writable=1 on the same edge: the write SHALL complete, then halted is set.
REQ-025 halted SHALL be cleared only by reset; deasserting flush does not clear it.
REQ-026 Memory contents SHALL initialise to all zeros at time zero.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force out1=0, out2=0, halted=0.
REQ-028 Reset SHALL NOT alter stored memory contents.
REQ-029 While rst_n=0, read and write requests SHALL be ignored; first active edge after release services requests normally.
REQ-030 Reset asserted mid-cycle between request and edge: request SHALL be dropped, no partial write.

Verification
REQ-031 After reset, read in=0x00000000 -> next edge out1=0, out2=0.
REQ-032 Write block A (bytes 0x00..0x7F ascending) to in=0x00000080, then read in=0x000000C5 -> out1=A, top byte of out1 = 0x00; read in=0x00000000 -> out2=A.
REQ-033 Same edge readable=1, writable=1, in=0x00000100, write=all-ones over zero block -> out1=0; next read -> out1=all-ones.
REQ-034 Write B to in=(MEM_BLOCKS-1)*128, C to in=0; read in=(MEM_BLOCKS-1)*128 -> out1=B, out2=C; read in=MEM_BLOCKS*128 -> out1=C (wrap).
REQ-035 Pulse flush=1 one cycle, then write D to in=0x00000200 -> read returns previous value; assert rst_n=0 then write D -> read returns D.
REQ-036 Assert rst_n=0 mid-cycle with out1 nonzero -> out1=0 before next edge; previously written blocks still read back unchanged.

Source files
------------

// File: rtl/datamem.sv
// Block-organised data memory: whole-block writes, and a dual read of the
// addressed block and its successor. A halt latch from the cache freezes writes.
module datamem #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_BYTES = 128,
    parameter int BLOCK_SIZE  = BLOCK_BYTES * 8,
    parameter int MEM_BLOCKS  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_SIZE-1:0]  in,
    input  logic                  readable,
    input  logic                  writable,
    input  logic [BLOCK_SIZE-1:0] write,
    output logic [BLOCK_SIZE-1:0] out1,
    output logic [BLOCK_SIZE-1:0] out2,
    input  logic                  flush
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(MEM_BLOCKS);

    // Contents start at zero and are deliberately outside the reset domain.
    logic [BLOCK_SIZE-1:0] r_mem [MEM_BLOCKS] = '{default: '0};

    logic [BLOCK_SIZE-1:0] r_out1;
    logic [BLOCK_SIZE-1:0] r_out2;
    logic                  r_halted;

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_wr_en;
    logic             w_unused_addr;

    // Block offset and address bits above the capacity play no part in indexing.
    assign w_idx         = in[OFF_W +: IDX_W];
    assign w_idx_nxt     = w_idx + IDX_W'(1);
    assign w_unused_addr = ^{in[OFF_W-1:0], in[WORD_SIZE-1:OFF_W+IDX_W]};

    // Old halted value is used, so a write on the flush edge still lands.
    assign w_wr_en = rst_n && writable && !r_halted;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out1 <= '0;
            r_out2 <= '0;
        end else if (readable) begin
            r_out1 <= r_mem[w_idx];
            r_out2 <= r_mem[w_idx_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (flush) begin
            r_halted <= 1'b1;
        end
    end

    assign out1 = r_out1;
    assign out2 = r_out2;

endmodule

// File: tb/tb_datamem.sv
// Scoreboard bench for datamem: stimulus pushes expected read blocks from a
// behavioural array model; a monitor compares the registered outputs each cycle.
module tb_datamem;

    localparam int NB  = 64;
    localparam int BSZ = 1024;

    typedef logic [BSZ-1:0] blk_t;
    typedef struct packed { blk_t o1; blk_t o2; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_s = '0;
    logic        readable = 1'b0;
    logic        writable = 1'b0;
    logic        flush = 1'b0;
    blk_t        wdata = '0;
    blk_t        out1, out2;

    datamem dut (
        .clk(clk), .rst_n(rst_n), .in(in_s), .readable(readable),
        .writable(writable), .write(wdata), .out1(out1), .out2(out2),
        .flush(flush)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    blk_t mem_m [NB];
    bit   halted_m = 1'b0;

    task automatic chk(input string nm, input blk_t act, input blk_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got top=%h low=%h, want top=%h low=%h",
                     nm, $time, act[BSZ-1 -: 128], act[63:0], exp[BSZ-1 -: 128], exp[63:0]);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 128) % NB);
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < BSZ / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One request cycle: inputs change on the falling edge, DUT samples on the next rising edge.
    task automatic issue(input bit rd, input bit wr, input bit fl,
                         input logic [31:0] a, input blk_t d);
        exp_t e;
        @(negedge clk);
        readable = rd; writable = wr; flush = fl; in_s = a; wdata = d;
        if (rd) begin
            e.o1 = mem_m[idx_of(a)];
            e.o2 = mem_m[(idx_of(a) + 1) % NB];
            exp_q.push_back(e);
        end
        if (wr && !halted_m) mem_m[idx_of(a)] = d;
        if (fl) halted_m = 1'b1;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 1'b0, $urandom, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        readable = 1'b0; writable = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        halted_m = 1'b0;
    endtask

    // Monitor: a sampled read updates the expected outputs; otherwise they must hold.
    initial begin : monitor
        exp_t last;
        bit   fire;
        last = '0;
        forever begin
            @(posedge clk);
            fire = rst_n && readable;
            #1;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    bad++; total++;
                    $display("FAIL scoreboard_underflow at %0t: got a read, want none", $time);
                end else begin
                    last = exp_q.pop_front();
                end
            end
            if (!rst_n) last = '0;
            chk("out1", out1, last.o1);
            chk("out2", out2, last.o2);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        blk_t a_blk, b_blk, c_blk, d_blk, ones, zero;
        int r;
        for (int i = 0; i < NB; i++) mem_m[i] = '0;
        zero = '0;
        ones = '1;
        for (int k = 0; k < 128; k++) a_blk[BSZ-1-8*k -: 8] = 8'(k);
        b_blk = rand_blk();
        c_blk = rand_blk();
        d_blk = rand_blk();

        repeat (2) @(negedge clk);
        chk("reset_out1", out1, zero);
        chk("reset_out2", out2, zero);
        rst_n = 1'b1;

        issue(1, 0, 0, 32'h0000_0000, '0);
        issue(0, 1, 0, 32'h0000_0080, a_blk);
        issue(1, 0, 0, 32'h0000_00C5, '0);
        issue(1, 0, 0, 32'h0000_0000, '0);
        idle();
        chk("top_byte", {1016'b0, out2[BSZ-1 -: 8]}, zero);

        issue(1, 1, 0, 32'h0000_0100, ones);
        issue(1, 0, 0, 32'h0000_0100, '0);
        issue(1, 1, 0, 32'h0000_0080, b_blk);
        issue(1, 0, 0, 32'h0000_0080, '0);
        issue(0, 1, 0, 32'h0000_0080, a_blk);

        issue(0, 1, 0, (NB-1)*128, b_blk);
        issue(0, 1, 0, 32'h0, c_blk);
        issue(1, 0, 0, (NB-1)*128, '0);
        issue(1, 0, 0, NB*128, '0);
        idle();

        issue(0, 0, 1, 32'h0, '0);
        issue(0, 1, 0, 32'h0000_0200, d_blk);
        issue(1, 0, 0, 32'h0000_0200, '0);
        idle();
        do_reset();
        issue(0, 1, 0, 32'h0000_0200, d_blk);
        issue(1, 0, 0, 32'h0000_0200, '0);
        idle();

        // Asynchronous reset between edges clears outputs immediately.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out1", out1, zero);
        chk("async_rst_out2", out2, zero);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        halted_m = 1'b0;
        issue(1, 0, 0, 32'h0000_0200, '0);
        issue(1, 0, 0, 32'h0000_0080, '0);
        issue(1, 0, 0, (NB-1)*128, '0);

        // Request pending when reset arrives is dropped.
        @(negedge clk);
        readable = 1'b1; writable = 1'b1; in_s = 32'h0000_0080; wdata = ones;
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        readable = 1'b0; writable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 0, 0, 32'h0000_0080, '0);

        // Flush on the same edge as a write: write lands, later writes do not.
        issue(0, 1, 1, 32'h0000_0300, b_blk);
        issue(0, 1, 0, 32'h0000_0300, c_blk);
        issue(1, 0, 0, 32'h0000_0300, '0);
        do_reset();

        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 199);
            if (r < 2) do_reset();
            else issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, r < 5,
                       (r < 60) ? (32'($urandom_range(0, NB-1)) * 128 + $urandom_range(0, 127)) : $urandom,
                       rand_blk());
        end
        idle();
        idle();
        @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
